// File: rtl/sc64_memory_pkg.sv
// Shared widths and types for the three-port SDRAM front-end arbiter.
package sc64_memory_pkg;
    localparam int ADDR_W  = 25;
    localparam int DATA_W  = 32;
    localparam int NUM_REQ = 3;
    localparam int BURST_W = 5;

    typedef logic [1:0] req_id_t;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    // Requester reached by stepping 'step' places round the ring from 'last'.
    function automatic req_id_t rr_step(req_id_t last, int step);
        return req_id_t'((int'(last) + step) % NUM_REQ);
    endfunction
endpackage

// File: rtl/memory_arbiter_tag_fifo.sv
// In-order FIFO of requester IDs, one entry per read still awaiting its ack.
module memory_arbiter_tag_fifo
    import sc64_memory_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    i_clk,
    input  logic    i_reset_n,
    input  logic    push,
    input  logic    pop,
    input  req_id_t id_in,
    output req_id_t head,
    output logic    empty,
    output logic    full,
    output logic    underflow
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_q, rd_q;
    logic [PW:0]   cnt_q;
    req_id_t       mem_q [DEPTH];
    logic          pop_ok;

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == (PW+1)'(DEPTH));
    assign underflow = pop && empty;
    assign pop_ok    = pop && !empty;
    assign head      = mem_q[rd_q];

    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_q] <= id_in;
    end

    // An ack with nothing outstanding is dropped here; the arbiter flags it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push)   wr_q <= wr_q + 1'b1;
            if (pop_ok) rd_q <= rd_q + 1'b1;
            if (push && !pop_ok)      cnt_q <= cnt_q + 1'b1;
            else if (!push && pop_ok) cnt_q <= cnt_q - 1'b1;
        end
    end
endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter of three requesters onto one SDRAM port, with bounded
// bursts and in-order routing of read acks back to the issuing requester.
module memory_arbiter
    import sc64_memory_pkg::*;
#(
    parameter int MAX_BURST = 16,
    parameter int TAG_DEPTH = 4
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic [NUM_REQ-1:0]        i_request,
    input  logic [NUM_REQ-1:0]        i_write,
    input  logic [NUM_REQ*ADDR_W-1:0] i_address,
    input  logic [NUM_REQ*DATA_W-1:0] i_data,
    output logic [NUM_REQ-1:0]        o_busy,
    output logic [NUM_REQ-1:0]        o_ack,
    output logic [DATA_W-1:0]         o_data,
    output logic                      o_mem_request,
    output logic                      o_mem_write,
    output logic [ADDR_W-1:0]         o_mem_address,
    output logic [DATA_W-1:0]         o_mem_data,
    input  logic                      i_mem_busy,
    input  logic                      i_mem_ack,
    input  logic [DATA_W-1:0]         i_mem_data,
    output logic                      o_error
);
    arb_state_t            state_q;
    req_id_t               owner_q, last_owner_q, rr_pick;
    logic [BURST_W-1:0]    burst_q, burst_d;
    logic                  error_q;

    logic [NUM_REQ-1:0][ADDR_W-1:0] addr_a;
    logic [NUM_REQ-1:0][DATA_W-1:0] data_a;
    logic own_req, stall, accept, push;
    logic fifo_empty, fifo_full, fifo_underflow;
    req_id_t fifo_head;

    assign addr_a = i_address;
    assign data_a = i_data;

    assign own_req       = i_request[owner_q];
    assign stall         = !i_write[owner_q] && fifo_full;
    assign o_mem_request = (state_q == GRANT) && own_req && !stall;
    assign o_mem_write   = i_write[owner_q];
    assign o_mem_address = addr_a[owner_q];
    assign o_mem_data    = data_a[owner_q];
    assign accept        = o_mem_request && !i_mem_busy;
    assign push          = accept && !i_write[owner_q];
    assign burst_d       = burst_q + 1'b1;
    assign o_data        = i_mem_data;
    assign o_error       = error_q;

    // Scan downwards so the nearest requester after last_owner wins.
    always_comb begin
        rr_pick = owner_q;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (i_request[rr_step(last_owner_q, k)]) rr_pick = rr_step(last_owner_q, k);
        end
    end

    always_comb begin
        for (int n = 0; n < NUM_REQ; n++) begin
            o_busy[n] = i_request[n] && !(accept && owner_q == req_id_t'(n));
            o_ack[n]  = i_mem_ack && !fifo_empty && fifo_head == req_id_t'(n);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= IDLE;
            last_owner_q <= req_id_t'(2);
            owner_q      <= '0;
            burst_q      <= '0;
            error_q      <= 1'b0;
        end else begin
            if (fifo_underflow) error_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (|i_request) begin
                        owner_q <= rr_pick;
                        burst_q <= '0;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (accept) burst_q <= burst_d;
                    if (!own_req || (accept && burst_d == BURST_W'(MAX_BURST))) begin
                        state_q      <= IDLE;
                        last_owner_q <= owner_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    memory_arbiter_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tags (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .push      (push),
        .pop       (i_mem_ack),
        .id_in     (owner_q),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .underflow (fifo_underflow)
    );
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench: a cycle table for the three-way read round, then hand
// sequences for bursts, FIFO stall, memory stall, error and reset cases.
module tb_memory_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req, wr, busy, ack;
    logic [2:0][24:0] addr_a;
    logic [2:0][31:0] data_a;
    logic [31:0] odata, mdata, mem_rdata;
    logic        mreq, mwr, mbusy, mack, err;
    logic [24:0] maddr;

    int total = 0, bad = 0;
    int mon_cnt = 0;
    logic mon_en = 1'b0;
    logic [31:0] mon_last = '0;

    always #5 clk = ~clk;

    memory_arbiter dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_request(req), .i_write(wr),
        .i_address(addr_a), .i_data(data_a), .o_busy(busy), .o_ack(ack),
        .o_data(odata), .o_mem_request(mreq), .o_mem_write(mwr),
        .o_mem_address(maddr), .o_mem_data(mdata), .i_mem_busy(mbusy),
        .i_mem_ack(mack), .i_mem_data(mem_rdata), .o_error(err)
    );

    always @(negedge clk) begin
        if (mon_en && mreq && !mbusy) begin
            mon_cnt  = mon_cnt + 1;
            mon_last = mdata;
        end
    end

    typedef struct {
        logic [2:0]  req;
        logic        mack;
        logic [31:0] mdat;
        logic [2:0]  busy;
        logic        mreq;
        logic [24:0] maddr;
        logic [2:0]  ack;
    } vec_t;

    vec_t tbl [12];

    function automatic vec_t mk(logic [2:0] r, logic a, logic [31:0] d,
                                logic [2:0] b, logic m, logic [24:0] ad, logic [2:0] k);
        vec_t v;
        v.req = r; v.mack = a; v.mdat = d; v.busy = b; v.mreq = m; v.maddr = ad; v.ack = k;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req = '0; wr = '0; mbusy = 1'b0; mack = 1'b0;
        cyc(); cyc();
    endtask

    // Hold requester 'id' until 'target' transfers have been taken in total.
    task automatic take(input int id, input int target, inout int n, input int limit);
        int c;
        c = 0;
        while (n < target && c < limit) begin
            req[id] = 1'b1;
            data_a[id] = 32'(n);
            @(negedge clk);
            if (!busy[id]) n++;
            cyc();
            c++;
        end
        data_a[id] = 32'(n);
    endtask

    localparam logic [24:0] A0 = 25'h0ABC00, A1 = 25'h0ABC01, A2 = 25'h0ABC02;

    initial begin
        int n, c;
        int acc [20];

        addr_a = {A2, A1, A0};
        data_a = '0;
        mem_rdata = '0;
        req = 3'b011; wr = '0; mbusy = 1'b0; mack = 1'b1;
        rst_n = 1'b0;
        #2;
        chk("rst_busy", 32'(busy), 32'h3);
        chk("rst_mreq", 32'(mreq), 32'h0);
        chk("rst_ack",  32'(ack),  32'h0);
        chk("rst_err",  32'(err),  32'h0);
        mack = 1'b0; req = '0;
        cyc();
        rst_n = 1'b1;

        // Round of single reads from all three: grant order 0,1,2, acks in order.
        tbl[0]  = mk(3'b111, 1'b0, 32'h0,        3'b111, 1'b0, 25'h0, 3'b000);
        tbl[1]  = mk(3'b111, 1'b0, 32'h0,        3'b110, 1'b1, A0,    3'b000);
        tbl[2]  = mk(3'b110, 1'b0, 32'h0,        3'b110, 1'b0, 25'h0, 3'b000);
        tbl[3]  = mk(3'b110, 1'b0, 32'h0,        3'b110, 1'b0, 25'h0, 3'b000);
        tbl[4]  = mk(3'b110, 1'b0, 32'h0,        3'b100, 1'b1, A1,    3'b000);
        tbl[5]  = mk(3'b100, 1'b0, 32'h0,        3'b100, 1'b0, 25'h0, 3'b000);
        tbl[6]  = mk(3'b100, 1'b0, 32'h0,        3'b100, 1'b0, 25'h0, 3'b000);
        tbl[7]  = mk(3'b100, 1'b0, 32'h0,        3'b000, 1'b1, A2,    3'b000);
        tbl[8]  = mk(3'b000, 1'b1, 32'hD000_0000, 3'b000, 1'b0, 25'h0, 3'b001);
        tbl[9]  = mk(3'b000, 1'b1, 32'hD000_0001, 3'b000, 1'b0, 25'h0, 3'b010);
        tbl[10] = mk(3'b000, 1'b1, 32'hD000_0002, 3'b000, 1'b0, 25'h0, 3'b100);
        tbl[11] = mk(3'b000, 1'b0, 32'h0,        3'b000, 1'b0, 25'h0, 3'b000);
        for (int i = 0; i < 12; i++) begin
            req = tbl[i].req; mack = tbl[i].mack; mem_rdata = tbl[i].mdat;
            @(negedge clk);
            chk($sformatf("t%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("t%0d_mreq", i), 32'(mreq), 32'(tbl[i].mreq));
            if (tbl[i].mreq) chk($sformatf("t%0d_addr", i), 32'(maddr), 32'(tbl[i].maddr));
            if (tbl[i].mack) chk($sformatf("t%0d_data", i), odata, tbl[i].mdat);
            chk($sformatf("t%0d_ack", i), 32'(ack), 32'(tbl[i].ack));
            cyc();
        end
        idle();

        // Requester 1 wants 20 writes: 16, forced release, re-grant for 4.
        wr = 3'b010; n = 0; c = 0;
        while (n < 20 && c < 100) begin
            req = 3'b010;
            data_a[1] = 32'(n);
            @(negedge clk);
            if (!busy[1]) begin
                acc[n] = c;
                chk("burst_wdata", mdata, 32'(n));
                chk("burst_wflag", 32'(mwr), 32'h1);
                n++;
            end
            cyc();
            c++;
        end
        chk("burst_total", 32'(n), 32'd20);
        chk("burst_first16", 32'(acc[15] - acc[0]), 32'd15);
        chk("burst_gap", 32'(acc[16] - acc[15]), 32'd2);
        chk("burst_last4", 32'(acc[19] - acc[16]), 32'd3);
        idle();

        // Requester 0: five reads with acks held back; fifth waits on an ack.
        n = 0;
        take(0, 4, n, 30);
        chk("fifo_acc4", 32'(n), 32'd4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("fifo_stall_busy", 32'(busy[0]), 32'h1);
            chk("fifo_stall_mreq", 32'(mreq), 32'h0);
            cyc();
        end
        mack = 1'b1; mem_rdata = 32'hA5A5_0000;
        @(negedge clk);
        chk("fifo_ack0", 32'(ack), 32'h1);
        chk("fifo_ack0_data", odata, 32'hA5A5_0000);
        cyc();
        mack = 1'b0;
        @(negedge clk);
        chk("fifo_5th_mreq", 32'(mreq), 32'h1);
        chk("fifo_5th_busy", 32'(busy[0]), 32'h0);
        cyc();
        req = '0;
        for (int i = 0; i < 4; i++) begin
            mack = 1'b1; mem_rdata = 32'(i + 1);
            @(negedge clk);
            chk("fifo_drain_ack", 32'(ack), 32'h1);
            cyc();
        end
        mack = 1'b0;
        @(negedge clk);
        chk("fifo_no_err", 32'(err), 32'h0);
        idle();

        // Requester 2 writes; controller stalls three cycles mid-burst.
        mon_cnt = 0; mon_en = 1'b1;
        wr = 3'b100; n = 0;
        take(2, 2, n, 20);
        mbusy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req[2] = 1'b1;
            @(negedge clk);
            chk("mbusy_busy", 32'(busy[2]), 32'h1);
            chk("mbusy_mreq", 32'(mreq), 32'h1);
            cyc();
        end
        mbusy = 1'b0;
        take(2, 4, n, 20);
        idle();
        mon_en = 1'b0;
        chk("mbusy_count", 32'(mon_cnt), 32'd4);
        chk("mbusy_last", mon_last, 32'd3);

        // Stray ack with nothing outstanding.
        mack = 1'b1;
        @(negedge clk);
        chk("stray_ack", 32'(ack), 32'h0);
        cyc();
        mack = 1'b0;
        @(negedge clk);
        chk("stray_err", 32'(err), 32'h1);
        repeat (3) cyc();
        chk("stray_err_hold", 32'(err), 32'h1);
        req = 3'b101; mack = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst2_err", 32'(err), 32'h0);
        chk("rst2_busy", 32'(busy), 32'h5);
        chk("rst2_mreq", 32'(mreq), 32'h0);
        chk("rst2_ack", 32'(ack), 32'h0);
        req = '0; mack = 1'b0;
        cyc();
        rst_n = 1'b1;
        idle();

        // Two reads in flight across a reset: their acks become errors.
        wr = '0; n = 0;
        take(0, 2, n, 20);
        chk("rr_acc2", 32'(n), 32'd2);
        req = '0;
        cyc();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        cyc();
        for (int i = 0; i < 2; i++) begin
            mack = 1'b1;
            @(negedge clk);
            chk("rr_no_ack", 32'(ack), 32'h0);
            cyc();
        end
        mack = 1'b0;
        @(negedge clk);
        chk("rr_err", 32'(err), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end
endmodule
